rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle resource (e.g. a sequential FSM/datapath unit) between N requesters.
- Issues one-hot registered grants and enforces a maximum hold time with forced preemption.
- After a preemption, applies a cooldown window in which no grant is issued.
- Sits between requester blocks and the shared unit; the unit's select is driven from owner/busy.

Parameters:
- N, 4, number of requesters (N>=2).
- MAX_HOLD, 8, maximum cycles a grant may be held before forced preemption (>=2).
- COOLDOWN, 2, cycles with no grant after a forced preemption (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- req  input  N  request vector, level-sensitive, held by the requester while it wants or owns the resource.
- rel  input  N  release strobe; only rel[owner] is honoured, and only in BUSY.
- gnt  output  N  one-hot grant, registered; all zeros when there is no owner.
- owner  output  clog2(N)  index of the current or last owner, registered.
- busy  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse on forced preemption.

Behaviour:
- Reset is asynchronous: rst_b=0 immediately forces the following values, including in the middle of a grant.
  - State: IDLE.
  - Outputs: gnt=0, busy=0, owner=0, timeout=0.
  - Internal: ptr=N-1, so requester 0 has top priority first; hold_cnt=0; cool_cnt=0.
- State encoding: one-hot with 3 states, IDLE=3'b001, BUSY=3'b010, COOL=3'b100.
- Arbitration (pick):
  - Winner is the first index with req set, searching circularly from ptr+1 mod N.
  - On a grant: ptr<=winner, owner<=winner, gnt<=onehot(winner), busy<=1, hold_cnt<=0, state<=BUSY.
- Latency: req sampled at edge k produces gnt visible from edge k, i.e. one cycle after req is first seen in IDLE.
- IDLE:
  - If any req is set, pick.
  - Otherwise stay in IDLE with gnt=0.
- BUSY: hold_cnt increments every cycle. Exit conditions, in priority order:
  - (a) rel[owner]=1 or req[owner]=0: normal release; next cycle gnt=0, busy=0, state IDLE, timeout=0.
  - (b) hold_cnt==MAX_HOLD-1 with no release: forced preemption; next cycle gnt=0, busy=0, timeout=1 for that single cycle, cool_cnt<=0, state COOL.
  - Otherwise remain in BUSY.
  - Consequences: gnt is high for at most MAX_HOLD consecutive cycles. If a release and the hold limit occur in the same cycle, the release wins and timeout is not asserted.
- Every ownership change passes through at least one cycle with gnt=0. There is no back-to-back BUSY->BUSY transition.
- COOL:
  - gnt=0; cool_cnt increments; timeout returns to 0 after the first COOL cycle.
  - When cool_cnt==COOLDOWN-1: if any req is set, pick (direct COOL->BUSY), otherwise go to IDLE.
  - Result: gnt is zero for exactly COOLDOWN cycles after a preemption when requests are pending.
- rel bits from non-owners and rel outside BUSY are ignored. rel is not latched.
- owner retains the last winner while gnt=0. Consumers must qualify owner with busy.
- Counter widths:
  - hold_cnt is clog2(MAX_HOLD) bits.
  - cool_cnt is clog2(COOLDOWN+1) bits.
  - Neither counter ever wraps: both are cleared on entry to their state.

Decomposition:
- Shared package/header holds:
  - one-hot state defines for IDLE, BUSY and COOL;
  - a clog2 helper;
  - default parameter values.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: any, winner index, one-hot winner.
  - Instantiated once in rr_arbiter.

Test Plan:
- Reset with req=4'b0000: gnt=0, busy=0, owner=0, timeout=0. Assert rst_b low mid-BUSY: gnt drops to 0 within the same cycle, without waiting for a clock edge.
- After reset, req=4'b1010: next cycle gnt=4'b0010, owner=1. Then rel=4'b0010 for one cycle: gnt=0 for one cycle, then gnt=4'b1000, owner=3.
- Fairness: req=4'b1111 held, with each owner pulsing its rel one cycle after being granted. Grant sequence is 0001, 0010, 0100, 1000, 0001, with one gnt=0 cycle between each.
- Timeout: req=4'b0001 held, rel=0. gnt=0001 for exactly 8 cycles, then timeout=1 for 1 cycle with gnt=0. gnt stays 0 for 2 cycles total, then gnt=0001 is re-issued.
- Ignored strobes: owner=1, req=4'b0110, rel=4'b0100: grant stays 0010. Then drop req[1]: next cycle gnt=0; following cycle gnt=4'b0100.
- Release coincident with hold limit: in the 8th held cycle, pulse rel[owner]. Required: timeout stays 0, state goes IDLE, and the next grant is issued one cycle later (no cooldown).

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared state encodings, defaults and clog2 helper for rr_arbiter
package rr_arbiter_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_COOLDOWN = 2;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_BUSY = 3'b010;
    localparam logic [2:0] ST_COOL = 3'b100;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational circular priority search starting just after ptr
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = clog2(DEF_N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] winner,
    output logic [N-1:0]  winner_oh
);

    logic [PW-1:0] cand;

    always_comb begin
        any       = 1'b0;
        winner    = '0;
        winner_oh = '0;
        cand      = '0;
        // Offsets 1..N visit every index once, ptr itself last.
        for (int i = 1; i <= N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
        if (any) begin
            winner_oh[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with hold limit, forced preemption and cooldown
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int COOLDOWN = DEF_COOLDOWN
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    output logic [N-1:0]         gnt,
    output logic [clog2(N)-1:0]  owner,
    output logic                 busy,
    output logic                 timeout
);

    localparam int OW = clog2(N);
    localparam int HW = clog2(MAX_HOLD);
    localparam int CW = clog2(COOLDOWN + 1);

    logic [2:0]    state;
    logic [OW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] cool_cnt;

    logic          pick_any;
    logic [OW-1:0] pick_idx;
    logic [N-1:0]  pick_oh;
    logic          cool_done;
    logic          do_pick;
    logic          owner_done;

    rr_pick #(
        .N  (N),
        .PW (OW)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .any       (pick_any),
        .winner    (pick_idx),
        .winner_oh (pick_oh)
    );

    assign cool_done  = (state == ST_COOL) && (cool_cnt == CW'(COOLDOWN - 1));
    assign do_pick    = pick_any && ((state == ST_IDLE) || cool_done);
    assign owner_done = rel[owner] || !req[owner];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            timeout  <= 1'b0;
            ptr      <= OW'(N - 1);
            hold_cnt <= '0;
            cool_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            if (do_pick) begin
                state    <= ST_BUSY;
                ptr      <= pick_idx;
                owner    <= pick_idx;
                gnt      <= pick_oh;
                busy     <= 1'b1;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_BUSY: begin
                        // A release in the limit cycle wins over preemption.
                        if (owner_done) begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                            state    <= ST_COOL;
                            gnt      <= '0;
                            busy     <= 1'b0;
                            timeout  <= 1'b1;
                            cool_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_COOL: begin
                        if (cool_done) begin
                            state <= ST_IDLE;
                        end else begin
                            cool_cnt <= cool_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - randomized and directed self-checking bench for rr_arbiter
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int COOLDOWN = 2;

    logic       clk;
    logic       rst_b;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int n_checks;
    int n_pass;

    // Reference model: mode 0 idle, 1 granted, 2 cooling down.
    int m_mode;
    int m_ptr;
    int m_owner;
    int m_held;
    int m_gap;
    bit m_to;

    rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode  = 0;
        m_ptr   = N - 1;
        m_owner = 0;
        m_held  = 0;
        m_gap   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_grant();
        for (int i = 1; i <= N; i++) begin
            if (req[(m_ptr + i) % N]) begin
                m_owner = (m_ptr + i) % N;
                m_ptr   = m_owner;
                m_mode  = 1;
                m_held  = 1;
                return;
            end
        end
    endtask

    task automatic model_tick();
        m_to = 1'b0;
        case (m_mode)
            0: if (req != 0) model_grant();
            1: begin
                if (rel[m_owner] || !req[m_owner]) begin
                    m_mode = 0;
                end else if (m_held == MAX_HOLD) begin
                    m_mode = 2;
                    m_to   = 1'b1;
                    m_gap  = 1;
                end else begin
                    m_held++;
                end
            end
            default: begin
                if (m_gap == COOLDOWN) begin
                    if (req != 0) model_grant();
                    else m_mode = 0;
                end else begin
                    m_gap++;
                end
            end
        endcase
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = (m_mode == 1) ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), (m_mode == 1), m_to};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {gnt, owner, busy, timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        req   = 4'b0000;
        rel   = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_vec() !== 8'h00) $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 8'h00);
        else n_pass++;
        rst_b = 1'b1;
        step();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_basic();
        req = 4'b1010;
        step();
        n_checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || obs_vec() !== exp_vec())
            $display("FAIL basic_first got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        rel = 4'b0010;
        step();
        rel = 4'b0000;
        n_checks++;
        if (gnt !== 4'b0000 || obs_vec() !== exp_vec())
            $display("FAIL basic_gap got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3 || obs_vec() !== exp_vec())
            $display("FAIL basic_second got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_fairness();
        logic [3:0] order[$];
        logic [3:0] prev;
        logic [3:0] want[5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = 4'b0000;
        req  = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL fair_model cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            if (gnt != 0 && prev == 0) order.push_back(gnt);
            n_checks++;
            if (gnt != 0 && prev != 0 && gnt != prev) $display("FAIL fair_no_gap got=%b exp=%b", gnt, 4'b0000);
            else n_pass++;
            prev = gnt;
            rel  = gnt;
        end
        rel = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (k >= order.size() || order[k] !== want[k])
                $display("FAIL fair_order idx=%0d got=%b exp=%b", k, (k < order.size()) ? order[k] : 4'bxxxx, want[k]);
            else n_pass++;
        end
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_timeout();
        logic [3:0] g[24];
        logic       t[24];
        int         hi;
        req = 4'b0001;
        rel = 4'b0000;
        for (int k = 0; k < 24; k++) begin
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL timeout_model cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            g[k] = gnt;
            t[k] = timeout;
        end
        hi = 0;
        while (hi < 20 && g[hi] == 4'b0001) hi++;
        n_checks++;
        if (hi != MAX_HOLD) $display("FAIL timeout_hold got=%0d exp=%0d", hi, MAX_HOLD);
        else n_pass++;
        n_checks++;
        if (hi > 20 || t[hi] !== 1'b1 || t[hi+1] !== 1'b0 || g[hi] !== 0 || g[hi+1] !== 0 || g[hi+2] !== 4'b0001)
            $display("FAIL timeout_cool got=%b%b%b/%b%b exp=000000000001/10",
                     g[hi], g[hi+1], g[hi+2], t[hi], t[hi+1]);
        else n_pass++;
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_ignored_rel();
        req = 4'b0110;
        step();
        rel = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0010 || obs_vec() !== exp_vec())
                $display("FAIL ignored_rel cyc=%0d got=%b exp=%b", k, gnt, 4'b0010);
            else n_pass++;
        end
        rel = 4'b0000;
        req = 4'b0100;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || obs_vec() !== exp_vec()) $display("FAIL drop_req_gap got=%b exp=%b", gnt, 4'b0000);
        else n_pass++;
        step();
        n_checks++;
        if (gnt !== 4'b0100 || obs_vec() !== exp_vec()) $display("FAIL drop_req_next got=%b exp=%b", gnt, 4'b0100);
        else n_pass++;
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_coincident();
        req = 4'b0001;
        step();
        repeat (MAX_HOLD - 1) step();
        rel = 4'b0001;
        step();
        rel = 4'b0000;
        n_checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0 || obs_vec() !== exp_vec())
            $display("FAIL coincident_rel got=%h exp=%h", obs_vec(), exp_vec());
        else n_pass++;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || obs_vec() !== exp_vec())
            $display("FAIL coincident_regrant got=%b exp=%b", gnt, 4'b0001);
        else n_pass++;
        req = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                if (errs < 10) $display("FAIL random cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
                errs++;
            end else n_pass++;
        end
        req = 4'b0000;
        rel = 4'b0000;
        repeat (2) step();
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        step();
        step();
        #2;
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0)
            $display("FAIL async_reset got=%h exp=%h", obs_vec(), 8'h00);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        req   = 4'b0110;
        step();
        n_checks++;
        if (gnt !== 4'b0010 || obs_vec() !== exp_vec())
            $display("FAIL post_reset_grant got=%b exp=%b", gnt, 4'b0010);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_fairness();
        test_timeout();
        test_ignored_rel();
        test_coincident();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
